// File: rtl/boot_ctrl.sv
// boot_ctrl: boot sequencer between a word-stream loader and the RISC-V core.
// Streams a program image into the Icache one word per accepted beat, holds
// the core in reset while loading and for RST_HOLD cycles afterwards, then
// releases it.
// Optional feature macro: BOOT_CHECKSUM_EN. When defined, the sum of all
// loaded words (mod 2^32) is compared with exp_sum at the end of the hold
// period, and a mismatch leaves the core in reset with err set.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start; core in reset
// LOAD  | accepting stream words and writing them into the Icache
// HOLD  | image complete, core still in reset for the guard period
// RUN   | core released and running; start triggers a reboot
// ERR   | illegal length or checksum mismatch; core in reset (sticky)
module boot_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_NUM   = 256,
  parameter int RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [31:0]           exp_sum,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  output logic                  s_ready,
  output logic                  boot_up,
  output logic [ADDR_WIDTH-1:0] boot_addr,
  output logic [31:0]           boot_datai,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN   = LW'(ADDR_NUM);
  localparam logic [7:0]    HOLD_INIT = 8'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] wcnt;
  logic [7:0]    hcnt;
  logic          len_ok;
  logic          accept;
  logic          last_beat;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0]   acc;
  logic [31:0]   sum_q;
`else
  logic          unused_exp_sum;
  assign unused_exp_sum = ^exp_sum;
`endif

  // A length of zero or beyond the Icache depth is rejected up front.
  assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
  assign accept    = s_valid && (state == LOAD);
  // wcnt stops at len_q, which never exceeds ADDR_NUM, so it cannot wrap.
  assign last_beat = accept && (wcnt == (len_q - LW'(1)));

  // Status outputs decoded straight from the state register.
  assign s_ready    = (state == LOAD);
  assign busy       = (state == LOAD) || (state == HOLD);
  assign done       = (state == RUN);
  assign err        = (state == ERR);
  assign core_rst_n = (state == RUN);

  // Boot FSM with counters, Icache write port and optional checksum.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      len_q      <= '0;
      wcnt       <= '0;
      hcnt       <= '0;
      boot_up    <= 1'b0;
      boot_addr  <= '0;
      boot_datai <= '0;
`ifdef BOOT_CHECKSUM_EN
      acc        <= '0;
      sum_q      <= '0;
`endif
    end else begin
      boot_up <= 1'b0;
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            if (len_ok) begin
              state <= LOAD;
              len_q <= load_len;
              wcnt  <= '0;
`ifdef BOOT_CHECKSUM_EN
              acc   <= '0;
              sum_q <= exp_sum;
`endif
            end else begin
              state <= ERR;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            boot_up    <= 1'b1;
            boot_addr  <= wcnt[ADDR_WIDTH-1:0];
            boot_datai <= s_data;
            wcnt       <= wcnt + LW'(1);
`ifdef BOOT_CHECKSUM_EN
            acc        <= acc + s_data;
`endif
            if (last_beat) begin
              state <= HOLD;
              hcnt  <= HOLD_INIT;
            end
          end
        end
        HOLD: begin
          if (hcnt == 8'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state <= (acc != sum_q) ? ERR : RUN;
`else
            state <= RUN;
`endif
          end else begin
            hcnt <= hcnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboard bench for boot_ctrl: the stimulus pushes each expected Icache
// write (address, data, cycle) into a queue; a monitor pops and compares
// whenever boot_up is seen.
module tb_boot_ctrl;
  localparam int AW = 8;
  localparam int AN = 256;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          start;
  logic [AW:0]   load_len;
  logic [31:0]   exp_sum;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          boot_up;
  logic [AW-1:0] boot_addr;
  logic [31:0]   boot_datai;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] wbuf [8];
  int          c0;
  int          last;

  boot_ctrl #(.ADDR_WIDTH(AW), .ADDR_NUM(AN), .RST_HOLD(H)) dut (
    .clk(clk), .srst(srst), .start(start), .load_len(load_len),
    .exp_sum(exp_sum), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .boot_up(boot_up), .boot_addr(boot_addr),
    .boot_datai(boot_datai), .core_rst_n(core_rst_n), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every Icache write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (boot_up === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required no write (cycle %0d)",
                 boot_addr, boot_datai, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 64'(boot_addr), 64'(mon_e.a));
        chk("write_data", 64'(boot_datai), 64'(mon_e.d));
        chk("write_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  // Called at a falling edge; returns at the next falling edge (cycle T+1).
  task automatic do_start(input int len, input logic [31:0] sum, output int c);
    start    = 1'b1;
    load_len = (AW+1)'(len);
    exp_sum  = sum;
    c        = cyc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Drive wbuf words following a valid pattern (bit i = valid in step i).
  task automatic send(input int plen, input logic [15:0] vpat, input bit ends, output int lst);
    int  k = 0;
    wr_t e;
    lst = cyc;
    for (int i = 0; i < plen; i++) begin
      if (vpat[i]) begin
        s_valid = 1'b1;
        s_data  = wbuf[k];
        e.a = AW'(k);
        e.d = wbuf[k];
        e.c = cyc + 1;
        exp_q.push_back(e);
        chk("s_ready_load", 64'(s_ready), 64'd1);
        lst = cyc;
        k++;
      end else begin
        s_valid = 1'b0;
        s_data  = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = 32'hDEADBEEF;
    if (ends) chk("s_ready_after_last", 64'(s_ready), 64'd0);
  endtask

  // Release (or error) must appear exactly RST_HOLD cycles after L+1.
  task automatic wait_end(input int lst, input bit exp_err);
    int rel = lst + 1 + H;
    bit early = 1'b0;
    for (int i = 0; i < 64 && cyc < rel; i++) begin
      if (done || err || core_rst_n) early = 1'b1;
      @(negedge clk);
    end
    chk("early_release", 64'(early), 64'd0);
    chk("end_done", 64'(done), 64'(!exp_err));
    chk("end_err", 64'(err), 64'(exp_err));
    chk("end_core_rst_n", 64'(core_rst_n), 64'(!exp_err));
    chk("end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    bit bad;
    srst = 1'b1; start = 1'b0; load_len = '0; exp_sum = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_boot_up", 64'(boot_up), 64'd0);
    chk("rst_boot_addr", 64'(boot_addr), 64'd0);
    chk("rst_boot_datai", 64'(boot_datai), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    srst = 1'b0;
    @(negedge clk);

    // Nominal back-to-back load of four words.
    wbuf[0] = 32'h00000013; wbuf[1] = 32'h00100093;
    wbuf[2] = 32'h00208113; wbuf[3] = 32'h0000006F;
    do_start(4, 32'h0, c0);
    chk("nom_busy", 64'(busy), 64'd1);
    send(4, 16'hF, 1'b1, last);
    wait_end(last, 1'b0);

    // Reboot from RUN: core reset drops on the start edge.
    wbuf[0] = 32'hA5A50001; wbuf[1] = 32'h5A5A0002;
    do_start(2, 32'h0, c0);
    chk("reboot_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("reboot_done", 64'(done), 64'd0);
    chk("reboot_s_ready", 64'(s_ready), 64'd1);
    send(2, 16'h3, 1'b1, last);
    wait_end(last, 1'b0);

    // Backpressure: valid 1,0,0,1,1,0,1.
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    do_start(4, 32'h0, c0);
    send(7, 16'b1011001, 1'b1, last);
    wait_end(last, 1'b0);

    // Illegal lengths, then recovery with a one-word image.
    do_start(0, 32'h0, c0);
    chk("ill0_err", 64'(err), 64'd1);
    chk("ill0_s_ready", 64'(s_ready), 64'd0);
    chk("ill0_core_rst_n", 64'(core_rst_n), 64'd0);
    do_start(AN + 1, 32'h0, c0);
    chk("ill_max_err", 64'(err), 64'd1);
    chk("ill_max_s_ready", 64'(s_ready), 64'd0);
    wbuf[0] = 32'hCAFEF00D;
    do_start(1, 32'h0, c0);
    chk("recover_err", 64'(err), 64'd0);
    chk("recover_s_ready", 64'(s_ready), 64'd1);
    send(1, 16'h1, 1'b1, last);
    wait_end(last, 1'b0);

    // Synchronous reset after two of eight words.
    wbuf[0] = 32'h0BAD0000; wbuf[1] = 32'h0BAD0001;
    do_start(8, 32'h0, c0);
    send(2, 16'h3, 1'b0, last);
    srst = 1'b1;
    @(negedge clk);
    chk("mid_s_ready", 64'(s_ready), 64'd0);
    chk("mid_boot_up", 64'(boot_up), 64'd0);
    chk("mid_boot_addr", 64'(boot_addr), 64'd0);
    chk("mid_boot_datai", 64'(boot_datai), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    srst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (core_rst_n || done || busy) bad = 1'b1;
      @(negedge clk);
    end
    chk("mid_stays_reset", 64'(bad), 64'd0);
    wbuf[0] = 32'h00000001; wbuf[1] = 32'h00000002; wbuf[2] = 32'h00000003;
    do_start(3, 32'd6, c0);
    send(3, 16'h7, 1'b1, last);
    wait_end(last, 1'b0);

    // Same image with a wrong expected checksum.
    do_start(3, 32'd7, c0);
    send(3, 16'h7, 1'b1, last);
`ifdef BOOT_CHECKSUM_EN
    wait_end(last, 1'b1);
`else
    wait_end(last, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot sequencer between an external word-stream loader and the RISC-V core. It accepts a program image over a valid/ready stream and writes it word by word into the Icache through `boot_up`/`boot_addr`/`boot_datai`. It holds the core in reset during loading and for a programmable guard period afterwards, then releases it. It sits at top level, ahead of `top_riscv_core`, and is the only driver of the core's boot and reset inputs.

## Interface
- `ADDR_WIDTH`, default 8: Icache word-address width.
- `ADDR_NUM`, default 256: Icache depth in words; maximum legal image length.
- `RST_HOLD`, default 4: cycles the core reset stays asserted after the last Icache write. Legal range is 1..255.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a boot.
- `load_len`  in  ADDR_WIDTH+1  image length in words. Sampled on `start`.
- `exp_sum`  in  32  expected image checksum. Sampled on `start`. Used only with `BOOT_CHECKSUM_EN`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  32  stream word.
- `s_ready`  out  1  block accepts a word this cycle.
- `boot_up`  out  1  Icache write enable; connects to core `boot_up`.
- `boot_addr`  out  ADDR_WIDTH  Icache word address.
- `boot_datai`  out  32  Icache write data.
- `core_rst_n`  out  1  active-low reset to the core.
- `busy`  out  1  boot in progress.
- `done`  out  1  core released and running.
- `err`  out  1  sticky boot failure.

## Operation
- States: IDLE, LOAD, HOLD, RUN, ERR. All outputs are registered or decoded directly from the state register.
- Output decoding:
  - `s_ready` = (state == LOAD).
  - `busy` = LOAD or HOLD.
  - `done` = RUN.
  - `err` = ERR.
  - `core_rst_n` = 1 only in RUN.
- IDLE → LOAD on `start` with 1 ≤ `load_len` ≤ `ADDR_NUM`. The transition does the following:
  - latches `load_len`;
  - clears the word counter `wcnt`;
  - clears the checksum accumulator.
- IDLE → ERR on `start` with `load_len` == 0 or `load_len` > `ADDR_NUM`.
- LOAD: a beat is accepted when `s_valid` && `s_ready`. On an accepted beat:
  - the next cycle presents `boot_up`=1, `boot_addr`=`wcnt[ADDR_WIDTH-1:0]`, `boot_datai`=`s_data`;
  - `wcnt` increments;
  - the accumulator adds `s_data`, mod 2^32.
- LOAD → HOLD: on the cycle the beat with `wcnt` == `load_len`−1 is accepted. The hold counter loads `RST_HOLD`−1.
- HOLD: the hold counter decrements each cycle. At 0:
  - → RUN, or
  - → ERR when `BOOT_CHECKSUM_EN` is defined and accumulator ≠ latched `exp_sum`.
- RUN: `start` with a legal length → LOAD (reboot). `core_rst_n` drops on the same edge the state leaves RUN. `start` with an illegal length → ERR.
- ERR: core is held in reset. `start` with a legal length → LOAD and clears `err`. `start` with an illegal length stays in ERR.
- `start` while in LOAD or HOLD is ignored.
- `boot_up` is 0 on every cycle not immediately following an accepted beat. `boot_addr`/`boot_datai` hold their last values when `boot_up`=0.
- `wcnt` never wraps. The maximum written address is `ADDR_NUM`−1.

## Timing
- Reset values: `s_ready`=0, `boot_up`=0, `boot_addr`=0, `boot_datai`=0, `core_rst_n`=0, `busy`=0, `done`=0, `err`=0. State is IDLE, all counters and the accumulator are 0.
- `srst` mid-boot aborts immediately to the reset values. There is no partial release.
- Start to first possible accept: `start` in cycle T → `s_ready`=1 in T+1.
- Write latency: a beat accepted in cycle N → Icache write in cycle N+1.
- Back-to-back: one word per cycle with `s_valid` held high.
- Release timing: last beat accepted in cycle L →
  - last `boot_up` pulse in L+1;
  - `s_ready`=0 from L+1;
  - `core_rst_n`=1 (or `err`=1) from cycle L+1+`RST_HOLD`.
- Total boot with no stalls: `load_len`+1+`RST_HOLD` cycles from `start` to `done`.

## Configuration
- Macro: `BOOT_CHECKSUM_EN`.
- Defined: the accumulator is kept, and a mismatch at the end of HOLD routes to ERR with the core left in reset.
- Undefined: there is no accumulator or compare logic. `exp_sum` is present but ignored, and HOLD always exits to RUN.

## Test plan
- Nominal load: `load_len`=4, words 0x00000013, 0x00100093, 0x00208113, 0x0000006F with `s_valid` held high.
  - Expect `boot_up` pulses at addresses 0..3 on cycles T+2..T+5.
  - Expect `core_rst_n`=1 and `done`=1 from T+5+`RST_HOLD`.
- Backpressure gaps: `s_valid` toggling 1,0,0,1,1,0,1 for `load_len`=4.
  - Expect exactly 4 `boot_up` pulses with contiguous addresses 0..3.
  - Expect no write on idle cycles.
- Illegal length: `start` with `load_len`=0, then with `ADDR_NUM`+1.
  - Expect `err`=1 next cycle and `s_ready`=0.
  - Then a legal `start` with `load_len`=1 clears `err` and enters LOAD.
- Reset mid-load: assert `srst` after 2 of 8 words.
  - Expect all outputs at reset values next cycle and `core_rst_n` to stay 0.
  - A subsequent `start` writes from address 0.
- Checksum (with the macro): words 1, 2, 3 with `exp_sum`=6 → RUN; the same image with `exp_sum`=7 → `err`=1 at L+1+`RST_HOLD` and `core_rst_n` stays 0. Without the macro, both cases reach RUN.
- Reboot from RUN: `start` with `load_len`=2.
  - Expect `core_rst_n`=0 on the next edge.
  - Expect a new load at addresses 0..1, followed by release.
